conv33_scale_bank: RTL and testbench

Per-output-channel requantisation scale store for the conv33 datapath, replacing the single-register scale input. It accepts a burst of NUM_CH scale words, one per output channel, and serves them by channel index with one-cycle registered read latency to the conv33 requantiser. A loader FSM tracks burst progress and signals completion. An optional shadow bank allows the next layer's scales to load while the current layer's scales are being read.

---
 rtl/conv33_scale_bank_pkg.sv | 13 +
 rtl/conv33_scale_regfile.sv | 46 ++++
 rtl/conv33_scale_bank.sv | 171 +++++++++++++++++
 tb/tb_conv33_scale_bank.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv33_scale_bank_pkg.sv
// Shared conv33 definitions: loader FSM states and default scale-store geometry.
package conv33_scale_bank_pkg;

  localparam int SCALE_WIDTH_DEF = 24;
  localparam int NUM_CH_DEF      = 16;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2
  } load_state_t;

endpackage : conv33_scale_bank_pkg

// File: rtl/conv33_scale_regfile.sv
// NUM_CH x SCALE_WIDTH scale register array: one synchronous write port and
// one registered read port. The read register holds its value when no read
// is issued, and a same-cycle write to the read address is not forwarded
// (read-before-write).
module conv33_scale_regfile #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array with a registered read port.
  // NOTE: the array is reset so a freshly reset block never exposes stale
  // scales; this makes it a flop array rather than an inferred RAM macro.
  // NOTE: non-blocking assignments keep the read sampling the pre-write
  // contents of r_mem, which is what gives read-before-write behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule : conv33_scale_regfile

// File: rtl/conv33_scale_bank.sv
// Per-output-channel requantisation scale store for the conv33 datapath.
// Accepts a burst of NUM_CH scale words and serves them by channel index with
// one-cycle registered read latency.
// Optional feature: define CONV33_SCALE_SHADOW_EN to add a shadow bank so the
// next layer's scales load while the current set stays readable.
module conv33_scale_bank
  import conv33_scale_bank_pkg::*;
#(
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [SCALE_WIDTH-1:0] load_data,
  input  logic                   load_clear,
  input  logic                   read_en,
  input  logic [CH_W-1:0]        read_ch,
  output logic [SCALE_WIDTH-1:0] scale,
  output logic                   valid,
  output logic                   scale_load,
  output logic                   ready,
  output logic                   rd_err
);

  localparam logic [CH_W-1:0] LAST_PTR  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_X  = (CH_W + 1)'(NUM_CH);

  load_state_t     r_state;
  logic [CH_W-1:0] r_wr_ptr;
  logic            r_ready;
  logic            r_scale_load;
  logic            r_valid;
  logic            r_rd_err;

  logic            w_beat;
  logic            w_last;
  logic            w_rd_ok;

  // load_clear wins over load_en: a cleared cycle never writes.
  assign w_beat  = load_en & ~load_clear;
  assign w_last  = w_beat & (r_wr_ptr == LAST_PTR);
  assign w_rd_ok = read_en & r_ready & ({1'b0, read_ch} < NUM_CH_X);

`ifdef CONV33_SCALE_SHADOW_EN
  // r_active selects the bank being read; loads go to the other one.
  logic                   r_active;
  logic                   r_rd_bank;
  logic [SCALE_WIDTH-1:0] w_rdata0;
  logic [SCALE_WIDTH-1:0] w_rdata1;
`else
  logic [SCALE_WIDTH-1:0] w_rdata0;
`endif

  // Loader FSM: write pointer, burst state, ready flag and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_wr_ptr     <= '0;
      r_ready      <= 1'b0;
      r_scale_load <= 1'b0;
`ifdef CONV33_SCALE_SHADOW_EN
      r_active     <= 1'b0;
`endif
    end else begin
      r_scale_load <= w_last;
      if (load_clear) begin
        r_wr_ptr <= '0;
        // Abort returns to whatever was readable before the burst; with a
        // single bank r_ready is already 0 here, so this lands in EMPTY.
        if (r_state == S_LOADING) begin
          r_state <= r_ready ? S_READY : S_EMPTY;
        end
      end else if (load_en) begin
        if (w_last) begin
          r_wr_ptr <= '0;
          r_state  <= S_READY;
          r_ready  <= 1'b1;
`ifdef CONV33_SCALE_SHADOW_EN
          r_active <= ~r_active;
`endif
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_state  <= S_LOADING;
`ifndef CONV33_SCALE_SHADOW_EN
          // The single bank is being overwritten, so the set is no longer whole.
          r_ready  <= 1'b0;
`endif
        end
      end
    end
  end

  // Read handshake: valid or rd_err one cycle after each read request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_rd_err <= 1'b0;
`ifdef CONV33_SCALE_SHADOW_EN
      r_rd_bank <= 1'b0;
`endif
    end else begin
      r_valid  <= w_rd_ok;
      r_rd_err <= read_en & ~w_rd_ok;
`ifdef CONV33_SCALE_SHADOW_EN
      // Remember which bank produced the last accepted read so scale holds it.
      if (w_rd_ok) begin
        r_rd_bank <= r_active;
      end
`endif
    end
  end

`ifdef CONV33_SCALE_SHADOW_EN
  conv33_scale_regfile #(
    .WIDTH (SCALE_WIDTH),
    .DEPTH (NUM_CH),
    .AW    (CH_W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_beat & r_active),
    .i_waddr (r_wr_ptr),
    .i_wdata (load_data),
    .i_re    (w_rd_ok & ~r_active),
    .i_raddr (read_ch),
    .o_rdata (w_rdata0)
  );

  conv33_scale_regfile #(
    .WIDTH (SCALE_WIDTH),
    .DEPTH (NUM_CH),
    .AW    (CH_W)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_beat & ~r_active),
    .i_waddr (r_wr_ptr),
    .i_wdata (load_data),
    .i_re    (w_rd_ok & r_active),
    .i_raddr (read_ch),
    .o_rdata (w_rdata1)
  );

  assign scale = r_rd_bank ? w_rdata1 : w_rdata0;
`else
  conv33_scale_regfile #(
    .WIDTH (SCALE_WIDTH),
    .DEPTH (NUM_CH),
    .AW    (CH_W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_beat),
    .i_waddr (r_wr_ptr),
    .i_wdata (load_data),
    .i_re    (w_rd_ok),
    .i_raddr (read_ch),
    .o_rdata (w_rdata0)
  );

  assign scale = w_rdata0;
`endif

  assign valid      = r_valid;
  assign scale_load = r_scale_load;
  assign ready      = r_ready;
  assign rd_err     = r_rd_err;

endmodule : conv33_scale_bank

// File: tb/tb_conv33_scale_bank.sv
// Directed bench for conv33_scale_bank: a 16-channel instance and a
// 12-channel instance sharing clock and reset. Shadow-bank expectations are
// selected with CONV33_SCALE_SHADOW_EN.
module tb_conv33_scale_bank;
  import conv33_scale_bank_pkg::*;

  logic        clk;
  logic        rst;

  // 16-channel instance
  logic        load_en, load_clear, read_en;
  logic [23:0] load_data;
  logic [3:0]  read_ch;
  logic [23:0] scale;
  logic        valid, scale_load, ready, rd_err;

  // 12-channel instance
  logic        b_load_en, b_load_clear, b_read_en;
  logic [23:0] b_load_data;
  logic [3:0]  b_read_ch;
  logic [23:0] b_scale;
  logic        b_valid, b_scale_load, b_ready, b_rd_err;

  int checks   = 0;
  int failures = 0;
  int pulses;

`ifdef CONV33_SCALE_SHADOW_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif

  conv33_scale_bank #(.SCALE_WIDTH(24), .NUM_CH(16), .CH_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_data  (load_data),
    .load_clear (load_clear),
    .read_en    (read_en),
    .read_ch    (read_ch),
    .scale      (scale),
    .valid      (valid),
    .scale_load (scale_load),
    .ready      (ready),
    .rd_err     (rd_err)
  );

  conv33_scale_bank #(.SCALE_WIDTH(24), .NUM_CH(12), .CH_W(4)) dut12 (
    .clk        (clk),
    .rst        (rst),
    .load_en    (b_load_en),
    .load_data  (b_load_data),
    .load_clear (b_load_clear),
    .read_en    (b_read_en),
    .read_ch    (b_read_ch),
    .scale      (b_scale),
    .valid      (b_valid),
    .scale_load (b_scale_load),
    .ready      (b_ready),
    .rd_err     (b_rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_en = 0; load_clear = 0; read_en = 0; load_data = '0; read_ch = '0;
    b_load_en = 0; b_load_clear = 0; b_read_en = 0; b_load_data = '0; b_read_ch = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_scale", 32'(scale), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_scale_load", 32'(scale_load), 32'h0);
    check("rst_rd_err", 32'(rd_err), 32'h0);

    // Read before anything is loaded is rejected
    read_en = 1; read_ch = 4'd3;
    tick();
    read_en = 0;
    check("empty_rd_err", 32'(rd_err), 32'h1);
    check("empty_valid", 32'(valid), 32'h0);
    check("empty_ready", 32'(ready), 32'h0);
    check("empty_scale", 32'(scale), 32'h0);

    // Full burst, no gaps
    for (int i = 0; i < 16; i++) begin
      load_en = 1; load_data = 24'h000100 + 24'(i);
      tick();
      if (i == 0)  check("burst_rd_err_clr", 32'(rd_err), 32'h0);
      if (i == 14) begin
        check("burst_ready_early", 32'(ready), 32'h0);
        check("burst_sl_early", 32'(scale_load), 32'h0);
      end
    end
    load_en = 0;
    check("burst_scale_load", 32'(scale_load), 32'h1);
    check("burst_ready", 32'(ready), 32'h1);

    // Back-to-back reads
    read_en = 1; read_ch = 4'd5;
    tick();
    check("sl_one_cycle", 32'(scale_load), 32'h0);
    check("rd5_valid", 32'(valid), 32'h1);
    check("rd5_scale", 32'(scale), 32'h000105);
    read_ch = 4'd15;
    tick();
    read_en = 0;
    check("rd15_valid", 32'(valid), 32'h1);
    check("rd15_scale", 32'(scale), 32'h00010F);
    tick();
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_scale_hold", 32'(scale), 32'h00010F);

    // NUM_CH=12 instance: out-of-range read and wrap at 12
    for (int i = 0; i < 12; i++) begin
      b_load_en = 1; b_load_data = 24'h000300 + 24'(i);
      tick();
    end
    b_load_en = 0;
    check("c12_scale_load", 32'(b_scale_load), 32'h1);
    check("c12_ready", 32'(b_ready), 32'h1);
    b_read_en = 1; b_read_ch = 4'd13;
    tick();
    check("c12_oob_rd_err", 32'(b_rd_err), 32'h1);
    check("c12_oob_valid", 32'(b_valid), 32'h0);
    b_read_ch = 4'd11;
    tick();
    b_read_en = 0;
    check("c12_rd11", 32'(b_scale), 32'h00030B);
    check("c12_rd11_valid", 32'(b_valid), 32'h1);
    for (int i = 0; i < 14; i++) begin
      b_load_en = 1; b_load_data = 24'h000400 + 24'(i);
      tick();
      if (i == 11) check("c12_wrap_sl", 32'(b_scale_load), 32'h1);
    end
    b_load_en = 0;
    check("c12_reload_ready", 32'(b_ready), SHADOW ? 32'h1 : 32'h0);
    for (int i = 0; i < 10; i++) begin
      b_load_en = 1; b_load_data = 24'h000500 + 24'(i);
      tick();
    end
    b_load_en = 0;
    check("c12_second_sl", 32'(b_scale_load), 32'h1);
    b_read_en = 1; b_read_ch = 4'd0;
    tick();
    check("c12_rd0", 32'(b_scale), 32'h00040C);
    b_read_ch = 4'd1;
    tick();
    check("c12_rd1", 32'(b_scale), 32'h00040D);
    b_read_ch = 4'd2;
    tick();
    b_read_en = 0;
    check("c12_rd2", 32'(b_scale), 32'h000500);

    // Partial burst, clear (with load_en in the same cycle), then full burst
    for (int i = 0; i < 7; i++) begin
      load_en = 1; load_data = 24'h00BB00 + 24'(i);
      tick();
      if (i == 0) check("partial_ready", 32'(ready), SHADOW ? 32'h1 : 32'h0);
    end
    load_clear = 1; load_en = 1; load_data = 24'hEEEEEE;
    tick();
    load_clear = 0; load_en = 0;
    check("clear_ready", 32'(ready), SHADOW ? 32'h1 : 32'h0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      load_en = 1; load_data = 24'h00AA00 + 24'(i);
      tick();
      pulses += int'(scale_load);
    end
    load_en = 0;
    tick();
    pulses += int'(scale_load);
    check("aa_pulse_count", 32'(pulses), 32'h1);
    check("aa_ready", 32'(ready), 32'h1);
    read_en = 1; read_ch = 4'd0;
    tick();
    check("aa_rd0", 32'(scale), 32'h00AA00);
    read_ch = 4'd6;
    tick();
    read_en = 0;
    check("aa_rd6", 32'(scale), 32'h00AA06);

    // Same-cycle read and write of channel 0 returns the old contents
    read_en = 1; read_ch = 4'd0; load_en = 1; load_data = 24'h00CC00;
    tick();
    read_en = 0; load_en = 0;
    check("rbw_scale", 32'(scale), 32'h00AA00);
    check("rbw_valid", 32'(valid), 32'h1);
    check("rbw_ready", 32'(ready), SHADOW ? 32'h1 : 32'h0);
    load_clear = 1;
    tick();
    load_clear = 0;
    check("rbw_clear_ready", 32'(ready), SHADOW ? 32'h1 : 32'h0);

`ifdef CONV33_SCALE_SHADOW_EN
    // Shadow reload while reading ch 2 every cycle
    read_en = 1; read_ch = 4'd2;
    tick();
    check("sh_keep_a", 32'(scale), 32'h00AA02);
    for (int k = 0; k < 16; k++) begin
      load_en = 1; load_data = 24'h00DD00 + 24'(k);
      tick();
      check("sh_old_data", 32'(scale), 32'h00AA02);
      check("sh_ready", 32'(ready), 32'h1);
      check("sh_valid", 32'(valid), 32'h1);
    end
    load_en = 0;
    check("sh_scale_load", 32'(scale_load), 32'h1);
    tick();
    read_en = 0;
    check("sh_new_data", 32'(scale), 32'h00DD02);
`endif

    // Reset asserted during beat 9 of a burst
    for (int i = 0; i < 9; i++) begin
      load_en = 1; load_data = 24'h00EE00 + 24'(i);
      tick();
    end
    load_data = 24'h00EE09;
    rst = 1'b1;
    #1;
    check("midrst_scale", 32'(scale), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_ready", 32'(ready), 32'h0);
    check("midrst_scale_load", 32'(scale_load), 32'h0);
    check("midrst_rd_err", 32'(rd_err), 32'h0);
    check("midrst_state", 32'(dut.r_state), 32'(S_EMPTY));
    load_en = 0;
    tick();
    rst = 1'b0;
    read_en = 1; read_ch = 4'd0;
    tick();
    read_en = 0;
    check("post_rst_rd_err", 32'(rd_err), 32'h1);
    check("post_rst_valid", 32'(valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_conv33_scale_bank
